// File: rtl/generic_bus_if.sv
// generic_bus_if
// Simple request/response memory bus shared by the caches, the page walker
// and the bus controller.
//   addr, wdata, byte_en, ren, wen : request, driven by the requester
//   rdata, busy                    : response, driven by the responder
// A requester holds its request stable until it sees busy=0. That cycle is
// the completion cycle.
// Modports:
//   generic_bus : responder view (the side that serves a requester)
//   cpu         : requester view (the side that issues requests)
interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  byte_en;
  logic        ren;
  logic        wen;
  logic        busy;

  modport generic_bus (
    input  addr, wdata, byte_en, ren, wen,
    output rdata, busy
  );

  modport cpu (
    output addr, wdata, byte_en, ren, wen,
    input  rdata, busy
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
// Merges the icache (index 0), dcache (index 1) and page-walker (index 2)
// requesters onto one downstream memory bus. Each grant is held until the
// transaction completes or the owner withdraws its request. Priority is fixed
// (pw > dcache > icache). A starvation guard lets a waiting icache request win
// once STARVE_LIMIT foreign transactions have completed in front of it.
// Ports:
//   CLK, RST       : clock (rising edge), asynchronous active-high reset
//   pw_req_if      : page-walker requester
//   dcache_req_if  : dcache requester
//   icache_req_if  : icache requester
//   mem_if         : downstream memory bus
//   grant          : current owner index, 3 when the bus is idle
module memory_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               CLK,
  input  logic               RST,
  generic_bus_if.generic_bus pw_req_if,
  generic_bus_if.generic_bus dcache_req_if,
  generic_bus_if.generic_bus icache_req_if,
  generic_bus_if.cpu         mem_if,
  output logic [1:0]         grant
);
  // A zero limit disables the guard; keep the counter at least one bit wide.
  localparam int               CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0]       IDX_I   = 2'd0;
  localparam logic [1:0]       IDX_D   = 2'd1;
  localparam logic [1:0]       IDX_P   = 2'd2;
  localparam logic [1:0]       NONE    = 2'd3;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state, state_next;
  logic [1:0]       owner, owner_next;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_next;

  logic [2:0]  req;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [3:0]  own_byte_en;
  logic        own_ren;
  logic        own_wen;
  logic        owner_req;
  logic        completion;
  logic        guard_hit;
  logic [2:0]  busy_vec;
  logic [31:0] rdata_vec [3];

  assign req = {pw_req_if.ren     | pw_req_if.wen,
                dcache_req_if.ren | dcache_req_if.wen,
                icache_req_if.ren | icache_req_if.wen};

  // Owner's request mux. Everything is zero while idle, so the memory side
  // sees ren=wen=0 whenever there is no owner.
  always_comb begin
    own_addr    = '0;
    own_wdata   = '0;
    own_byte_en = '0;
    own_ren     = 1'b0;
    own_wen     = 1'b0;
    if (state == OWN) begin
      case (owner)
        IDX_I: begin
          own_addr    = icache_req_if.addr;
          own_wdata   = icache_req_if.wdata;
          own_byte_en = icache_req_if.byte_en;
          own_ren     = icache_req_if.ren;
          own_wen     = icache_req_if.wen;
        end
        IDX_D: begin
          own_addr    = dcache_req_if.addr;
          own_wdata   = dcache_req_if.wdata;
          own_byte_en = dcache_req_if.byte_en;
          own_ren     = dcache_req_if.ren;
          own_wen     = dcache_req_if.wen;
        end
        IDX_P: begin
          own_addr    = pw_req_if.addr;
          own_wdata   = pw_req_if.wdata;
          own_byte_en = pw_req_if.byte_en;
          own_ren     = pw_req_if.ren;
          own_wen     = pw_req_if.wen;
        end
        default: ;
      endcase
    end
  end

  assign mem_if.addr    = own_addr;
  assign mem_if.wdata   = own_wdata;
  assign mem_if.byte_en = own_byte_en;
  assign mem_if.ren     = own_ren;
  assign mem_if.wen     = own_wen;

  // owner_req is only ever set while owned, so completion implies OWN.
  assign owner_req  = own_ren | own_wen;
  assign completion = owner_req & ~mem_if.busy;
  assign guard_hit  = (STARVE_LIMIT != 0) && (starve_cnt == CNT_MAX) && req[0];

  // Responses: only the owner sees the memory side. Non-owner outputs depend
  // on registered state alone, which keeps requesters isolated from each other.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_resp
      logic is_owner;
      assign is_owner      = (state == OWN) && (owner == 2'(gi));
      assign busy_vec[gi]  = is_owner ? mem_if.busy : 1'b1;
      assign rdata_vec[gi] = is_owner ? mem_if.rdata : '0;
    end
  endgenerate

  assign icache_req_if.busy  = busy_vec[0];
  assign dcache_req_if.busy  = busy_vec[1];
  assign pw_req_if.busy      = busy_vec[2];
  assign icache_req_if.rdata = rdata_vec[0];
  assign dcache_req_if.rdata = rdata_vec[1];
  assign pw_req_if.rdata     = rdata_vec[2];

  assign grant = (state == OWN) ? owner : NONE;

  // Every grant ends in IDLE for at least one cycle, even when the finishing
  // master already holds its next request.
  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next = OWN;
          if (guard_hit)   owner_next = IDX_I;
          else if (req[2]) owner_next = IDX_P;
          else if (req[1]) owner_next = IDX_D;
          else             owner_next = IDX_I;
        end
      end
      OWN: begin
        if (!owner_req || completion) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counts foreign completions that an active icache request has sat through.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!req[0]) begin
      starve_cnt_next = '0;
    end else if (completion) begin
      if (owner == IDX_I)            starve_cnt_next = '0;
      else if (starve_cnt != CNT_MAX) starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= IDX_I;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      starve_cnt <= starve_cnt_next;
    end
  end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter
// Directed scenarios for memory_bus_arbiter (STARVE_LIMIT=2). Requester
// agents replay queued transactions and hold each one until busy=0 (or an
// abort point). A simple memory responds after a programmable number of busy
// cycles. A negedge process checks every DUT output against a transaction
// level model of the arbitration rules. The main sequence adds literal checks
// on grant logs and captured values.
module tb_memory_bus_arbiter;
  localparam int LIMIT = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] grant;

  generic_bus_if icache_if ();
  generic_bus_if dcache_if ();
  generic_bus_if pw_if ();
  generic_bus_if mem_if ();

  always #5 CLK = ~CLK;

  memory_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pw_req_if    (pw_if),
    .dcache_req_if(dcache_if),
    .icache_req_if(icache_if),
    .mem_if       (mem_if),
    .grant        (grant)
  );

  typedef struct {
    int          m;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          abort_after;
  } txn_t;

  // Requester drive values (index 0 icache, 1 dcache, 2 pw)
  logic        d_ren   [3] = '{1'b0, 1'b0, 1'b0};
  logic        d_wen   [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] d_addr  [3] = '{32'd0, 32'd0, 32'd0};
  logic [31:0] d_wdata [3] = '{32'd0, 32'd0, 32'd0};
  logic [3:0]  d_be    [3] = '{4'd0, 4'd0, 4'd0};
  logic [2:0]  r_busy;
  logic [31:0] r_rdata [3];

  assign icache_if.ren = d_ren[0];  assign icache_if.wen = d_wen[0];
  assign icache_if.addr = d_addr[0]; assign icache_if.wdata = d_wdata[0];
  assign icache_if.byte_en = d_be[0];
  assign dcache_if.ren = d_ren[1];  assign dcache_if.wen = d_wen[1];
  assign dcache_if.addr = d_addr[1]; assign dcache_if.wdata = d_wdata[1];
  assign dcache_if.byte_en = d_be[1];
  assign pw_if.ren = d_ren[2];      assign pw_if.wen = d_wen[2];
  assign pw_if.addr = d_addr[2];     assign pw_if.wdata = d_wdata[2];
  assign pw_if.byte_en = d_be[2];
  assign r_busy = {pw_if.busy, dcache_if.busy, icache_if.busy};
  assign r_rdata[0] = icache_if.rdata;
  assign r_rdata[1] = dcache_if.rdata;
  assign r_rdata[2] = pw_if.rdata;

  // Memory responder
  logic        mem_busy  = 1'b1;
  logic [31:0] mem_rdata = 32'd0;
  int          mem_lat   = 0;
  int          mem_cnt   = 0;
  assign mem_if.busy  = mem_busy;
  assign mem_if.rdata = mem_rdata;

  always @(posedge CLK) begin
    #2;
    if (mem_if.ren || mem_if.wen) begin
      mem_busy = (mem_cnt != mem_lat);
      mem_cnt++;
    end else begin
      mem_busy = 1'b1;
      mem_cnt  = 0;
    end
    mem_rdata = (mem_if.addr == 32'h100) ? 32'hDEADBEEF : ~mem_if.addr;
  end

  // Bookkeeping shared between agent, compare process and main sequence
  txn_t        tq [$];
  txn_t        cur [3];
  logic        active [3] = '{1'b0, 1'b0, 1'b0};
  int          done_cnt [3] = '{0, 0, 0};
  int          done_base [3] = '{0, 0, 0};
  int          owned_total [3] = '{0, 0, 0};
  int          own_base [3] = '{0, 0, 0};
  int          busy_low [3] = '{0, 0, 0};
  logic [31:0] done_rdata [3];
  int          glog [$];
  int          clog [$];
  int          alog [$];
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_ren, cap_wen;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Requester agents
  always @(posedge CLK) begin
    bit ab;
    #1;
    for (int m = 0; m < 3; m++) begin
      ab = 1'b0;
      if (active[m]) begin
        if (done_cnt[m] != done_base[m]) begin
          active[m] = 1'b0;
        end else if (cur[m].abort_after != 0 &&
                     (owned_total[m] - own_base[m]) == cur[m].abort_after) begin
          active[m] = 1'b0;
          ab = 1'b1;
        end
      end
      if (!active[m] && !ab) begin
        for (int i = 0; i < tq.size(); i++) begin
          if (tq[i].m == m) begin
            cur[m] = tq[i];
            tq.delete(i);
            active[m]    = 1'b1;
            done_base[m] = done_cnt[m];
            own_base[m]  = owned_total[m];
            break;
          end
        end
      end
      d_ren[m]   = active[m] && !cur[m].wen;
      d_wen[m]   = active[m] && cur[m].wen;
      d_addr[m]  = active[m] ? cur[m].addr : 32'd0;
      d_wdata[m] = active[m] ? cur[m].wdata : 32'd0;
      d_be[m]    = active[m] ? cur[m].be : 4'd0;
    end
  end

  // Reference model and per-cycle compare
  int exp_owner = -1;
  int exp_cnt   = 0;

  always @(negedge CLK) begin
    logic [2:0] r;
    logic       b;
    bit         comp;
    if (RST) begin
      exp_owner = -1;
      exp_cnt   = 0;
    end else begin
      for (int m = 0; m < 3; m++) r[m] = d_ren[m] | d_wen[m];
      b = mem_busy;
      chk("grant", 32'(grant), (exp_owner < 0) ? 32'd3 : 32'(exp_owner));
      chk("starve_cnt", 32'(dut.starve_cnt), 32'(exp_cnt));
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("busy%0d", m), 32'(r_busy[m]), (m == exp_owner) ? 32'(b) : 32'd1);
        chk($sformatf("rdata%0d", m), r_rdata[m], (m == exp_owner) ? mem_rdata : 32'd0);
      end
      if (exp_owner >= 0) begin
        chk("mem_ren", 32'(mem_if.ren), 32'(d_ren[exp_owner]));
        chk("mem_wen", 32'(mem_if.wen), 32'(d_wen[exp_owner]));
        chk("mem_addr", mem_if.addr, d_addr[exp_owner]);
        chk("mem_wdata", mem_if.wdata, d_wdata[exp_owner]);
        chk("mem_be", 32'(mem_if.byte_en), 32'(d_be[exp_owner]));
      end else begin
        chk("mem_ren", 32'(mem_if.ren), 32'd0);
        chk("mem_wen", 32'(mem_if.wen), 32'd0);
        chk("mem_addr", mem_if.addr, 32'd0);
        chk("mem_wdata", mem_if.wdata, 32'd0);
        chk("mem_be", 32'(mem_if.byte_en), 32'd0);
      end
      if (|r || grant != 2'd3) begin
        glog.push_back(int'(grant));
        clog.push_back(int'(dut.starve_cnt));
        alog.push_back(int'(mem_if.ren | mem_if.wen));
      end
      if (grant == 2'd2) begin
        cap_addr = mem_if.addr;  cap_wdata = mem_if.wdata;  cap_be = mem_if.byte_en;
        cap_ren  = mem_if.ren;   cap_wen   = mem_if.wen;
      end
      for (int m = 0; m < 3; m++) begin
        if (r[m] && !r_busy[m]) begin
          done_cnt[m]++;
          done_rdata[m] = r_rdata[m];
        end
        if (!r_busy[m]) busy_low[m]++;
        if (int'(grant) == m) owned_total[m]++;
      end
      // Advance the model to the next cycle.
      if (exp_owner < 0) begin
        if (|r) begin
          if (LIMIT != 0 && exp_cnt == LIMIT && r[0]) exp_owner = 0;
          else if (r[2]) exp_owner = 2;
          else if (r[1]) exp_owner = 1;
          else           exp_owner = 0;
        end
        if (!r[0]) exp_cnt = 0;
      end else begin
        comp = r[exp_owner] && !b;
        if (!r[0]) exp_cnt = 0;
        else if (comp) exp_cnt = (exp_owner == 0) ? 0 : ((exp_cnt < LIMIT) ? exp_cnt + 1 : LIMIT);
        if (!r[exp_owner] || comp) exp_owner = -1;
      end
    end
  end

  // Main sequence helpers
  int exp_q [$];

  task automatic push_txn(input int m, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int abort_after);
    txn_t t;
    t.m = m; t.wen = wen; t.addr = addr; t.wdata = wdata; t.be = be;
    t.abort_after = abort_after;
    tq.push_back(t);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge CLK); #3;
      ok = (tq.size() == 0) && !active[0] && !active[1] && !active[2] && (grant == 2'd3);
    end
    chk({"idle_", name}, 32'(ok), 32'd1);
  endtask

  task automatic check_log(input string name, input int start);
    chk({name, "_len"}, 32'(glog.size() - start), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (start + i < glog.size())
        chk($sformatf("%s_grant[%0d]", name, i), 32'(glog[start + i]), 32'(exp_q[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int bl0, bl2, dc0;
    bit seen;

    // Reset values
    #2;
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_mem_ren", 32'(mem_if.ren), 32'd0);
    chk("rst_mem_wen", 32'(mem_if.wen), 32'd0);
    chk("rst_mem_addr", mem_if.addr, 32'd0);
    chk("rst_mem_be", 32'(mem_if.byte_en), 32'd0);
    chk("rst_busy", 32'(r_busy), 32'h7);
    chk("rst_rdata_d", r_rdata[1], 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #3;

    // Single dcache read, memory busy for 3 cycles
    mem_lat = 3;
    start = glog.size(); bl0 = busy_low[0]; bl2 = busy_low[2]; dc0 = done_cnt[1];
    push_txn(1, 1'b0, 32'h100, 32'd0, 4'hF, 0);
    wait_idle("dread");
    exp_q = '{3, 1, 1, 1, 1};
    check_log("dread", start);
    chk("dread_done", 32'(done_cnt[1] - dc0), 32'd1);
    chk("dread_rdata", done_rdata[1], 32'hDEADBEEF);
    chk("dread_ic_busy", 32'(busy_low[0] - bl0), 32'd0);
    chk("dread_pw_busy", 32'(busy_low[2] - bl2), 32'd0);
    $display("txn dcache read 0x100: grant log checked");

    // All three request together, single-cycle memory
    mem_lat = 0;
    start = glog.size();
    push_txn(2, 1'b0, 32'h2000, 32'd0, 4'hF, 0);
    push_txn(1, 1'b0, 32'h1000, 32'd0, 4'hF, 0);
    push_txn(0, 1'b0, 32'h0040, 32'd0, 4'hF, 0);
    wait_idle("all3");
    exp_q = '{3, 2, 3, 1, 3, 0};
    check_log("all3", start);
    chk("all3_ic_rdata", done_rdata[0], ~32'h0040);
    $display("txn three-way contention: grant log checked");

    // Starvation guard: icache requests continuously, dcache back-to-back
    start = glog.size();
    push_txn(0, 1'b0, 32'h0080, 32'd0, 4'hF, 0);
    push_txn(0, 1'b0, 32'h0084, 32'd0, 4'hF, 0);
    for (int i = 0; i < 4; i++) push_txn(1, 1'b0, 32'h3000 + 32'(i * 4), 32'd0, 4'hF, 0);
    wait_idle("starve");
    exp_q = '{3, 1, 3, 1, 3, 0, 3, 1, 3, 1, 3, 0};
    check_log("starve", start);
    if (start + 6 < clog.size()) begin
      chk("starve_cnt_at_ic_grant", 32'(clog[start + 5]), 32'd2);
      chk("starve_cnt_after_ic", 32'(clog[start + 6]), 32'd0);
    end else begin
      chk("starve_cnt_log_len", 32'(clog.size()), 32'(start + 7));
    end
    $display("txn starvation guard: grant and counter logs checked");

    // Write pass-through from the page walker
    mem_lat = 1;
    start = glog.size();
    push_txn(2, 1'b1, 32'h8000_0040, 32'h1234_5678, 4'b0011, 0);
    wait_idle("pwwrite");
    exp_q = '{3, 2, 2};
    check_log("pwwrite", start);
    chk("pw_mem_addr", cap_addr, 32'h8000_0040);
    chk("pw_mem_wdata", cap_wdata, 32'h1234_5678);
    chk("pw_mem_be", 32'(cap_be), 32'h3);
    chk("pw_mem_wen", 32'(cap_wen), 32'd1);
    chk("pw_mem_ren", 32'(cap_ren), 32'd0);
    $display("txn pw write 0x80000040: pass-through checked");

    // Abort: dcache withdraws while memory is still busy, icache waiting
    mem_lat = 5;
    start = glog.size(); dc0 = done_cnt[1];
    push_txn(1, 1'b0, 32'h4000, 32'd0, 4'hF, 2);
    push_txn(0, 1'b0, 32'h0100, 32'd0, 4'hF, 0);
    wait_idle("abort");
    exp_q = '{3, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0};
    check_log("abort", start);
    if (start + 3 < alog.size()) begin
      chk("abort_mem_act_before", 32'(alog[start + 2]), 32'd1);
      chk("abort_mem_act", 32'(alog[start + 3]), 32'd0);
    end else begin
      chk("abort_alog_len", 32'(alog.size()), 32'(start + 4));
    end
    chk("abort_no_done", 32'(done_cnt[1] - dc0), 32'd0);
    $display("txn dcache abort: checked");

    // Asynchronous reset during an owned icache read
    mem_lat = 8;
    bl0 = busy_low[0]; dc0 = done_cnt[0];
    push_txn(0, 1'b0, 32'h0200, 32'd0, 4'hF, 0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge CLK); #3;
      seen = (grant == 2'd0);
    end
    chk("rst_test_granted", 32'(seen), 32'd1);
    RST = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 32'd3);
    chk("midrst_mem_ren", 32'(mem_if.ren), 32'd0);
    chk("midrst_ic_busy", 32'(icache_if.busy), 32'd1);
    mem_lat = 1;
    @(posedge CLK); #1;
    RST = 1'b0;
    start = glog.size();
    wait_idle("after_rst");
    exp_q = '{3, 0, 0};
    check_log("after_rst", start);
    chk("after_rst_done", 32'(done_cnt[0] - dc0), 32'd1);
    chk("after_rst_busy_low", 32'(busy_low[0] - bl0), 32'd1);
    chk("after_rst_rdata", done_rdata[0], ~32'h0200);
    $display("txn reset during icache read: checked");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
